// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the AES-128 decryption ring control logic.
//   sched_state_t   : scheduler FSM encoding
//   inflight_t      : live-block count (0..3)
//   AES_RING_DEPTH  : number of register sections in the recirculating ring
//   AES_DONE_STATE  : 5-bit round state at which a block leaving the last
//                     section is finished (the datapath does this compare
//                     and reports it as data_done)
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int         AES_RING_DEPTH = 3;
  localparam logic [4:0] AES_DONE_STATE = 5'd10;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, ACK} sched_state_t;

  typedef logic [1:0] inflight_t;

endpackage

// File: rtl/aes_decrypt_scheduler_if.sv
// ---------------------------------------------------------------------------
// aes_decrypt_scheduler_if
// Handshake bundle between the scheduler and its neighbours (input FIFO,
// datapath, key-expansion unit, output FIFO).
//   slave  : scheduler side (drives read_fifo, is_full, out_write,
//            key_change_ack, busy, inflight)
//   master : environment side (drives fifo_empty, data_done, out_full,
//            key_valid, key_change_req)
// ---------------------------------------------------------------------------
interface aes_decrypt_scheduler_if;
  import aes_pkg::*;

  logic      fifo_empty;
  logic      read_fifo;
  logic      data_done;
  logic      is_full;
  logic      out_full;
  logic      out_write;
  logic      key_valid;
  logic      key_change_req;
  logic      key_change_ack;
  logic      busy;
  inflight_t inflight;

  modport master (
    output fifo_empty, data_done, out_full, key_valid, key_change_req,
    input  read_fifo, is_full, out_write, key_change_ack, busy, inflight
  );

  modport slave (
    input  fifo_empty, data_done, out_full, key_valid, key_change_req,
    output read_fifo, is_full, out_write, key_change_ack, busy, inflight
  );

endinterface

// File: rtl/aes_ring_slot_tracker.sv
// ---------------------------------------------------------------------------
// aes_ring_slot_tracker
// Valid-bit shadow of the datapath ring sections plus the live-block count.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   stall         : output FIFO stall; everything holds
//   inject        : a new block enters section 0 at this edge
//   fin           : the block at the ring output is finished
//   retire        : the finished block is written out this cycle
//   last_valid    : slot at the ring output / re-entry mux is live
//   inflight      : registered live-block count
//   inflight_nxt  : count after this edge (used by the drain decision)
// ---------------------------------------------------------------------------
module aes_ring_slot_tracker
  import aes_pkg::*;
#(
  parameter int RING_DEPTH = AES_RING_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      stall,
  input  logic      inject,
  input  logic      fin,
  input  logic      retire,
  output logic      last_valid,
  output inflight_t inflight,
  output inflight_t inflight_nxt
);

  logic [RING_DEPTH-1:0] v;
  logic                  v_in;

  assign last_valid = v[RING_DEPTH-1];

  // A slot re-enters section 0 live if it was live and not finished, or
  // if a new block takes the slot this cycle.
  assign v_in = inject | (v[RING_DEPTH-1] & ~fin);

  // inject and retire are both forced low while stalled, so the next
  // count equals the current one during a stall.
  assign inflight_nxt = inflight + {1'b0, inject} - {1'b0, retire};

  always_ff @(posedge clk) begin
    if (rst) begin
      v        <= '0;
      inflight <= '0;
    end else if (!stall) begin
      v        <= {v[RING_DEPTH-2:0], v_in};
      inflight <= inflight_nxt;
    end
  end

endmodule

// File: rtl/aes_decrypt_scheduler.sv
// ---------------------------------------------------------------------------
// aes_decrypt_scheduler
// Sequencing controller for the recirculating AES-128 decryption ring.
// Injects ciphertext blocks from the input FIFO into free ring slots,
// retires finished blocks into the output FIFO, freezes the ring while the
// output FIFO is full and drains the ring ahead of a key change.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : handshake bundle (slave modport), see aes_decrypt_scheduler_if
// The round-state compare against AES_DONE_STATE lives in the datapath and
// arrives here as bus.data_done.
//
// state | meaning
// IDLE  | no key loaded or key dropped; no injection
// RUN   | normal operation; inject into free slots
// DRAIN | key change pending; no injection, live blocks finish
// ACK   | ring empty; key_change_ack pulses for one cycle
// ---------------------------------------------------------------------------
module aes_decrypt_scheduler
  import aes_pkg::*;
#(
  parameter int RING_DEPTH = AES_RING_DEPTH
) (
  input logic                    clk,
  input logic                    rst,
  aes_decrypt_scheduler_if.slave bus
);

  sched_state_t state_q;
  sched_state_t state_d;

  logic      last_valid;
  inflight_t inflight;
  inflight_t inflight_nxt;

  logic fin;
  logic stall;
  logic out_write;
  logic slot_free;
  logic read_fifo;
  logic key_change_ack;

  aes_ring_slot_tracker #(
    .RING_DEPTH (RING_DEPTH)
  ) u_slot_tracker (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .inject       (read_fifo),
    .fin          (fin),
    .retire       (out_write),
    .last_valid   (last_valid),
    .inflight     (inflight),
    .inflight_nxt (inflight_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The FSM holds during an output stall, except that a key change request
  // is still accepted: DRAIN only suppresses injection, which a stall
  // already does, so entering it early is harmless and keeps the request
  // latency independent of the output FIFO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!stall && bus.key_valid && !bus.key_change_req) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.key_change_req) begin
          state_d = DRAIN;
        end else if (!stall && !bus.key_valid && (inflight == '0)) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        // Looking at the post-edge count lets the ack land on the cycle
        // right after the last retire.
        if (!stall && (inflight_nxt == '0)) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // data_done only counts when the slot at the ring output is live; bubble
  // slots carry garbage whose round state can alias the done value.
  always_comb begin
    fin            = 1'b0;
    stall          = 1'b0;
    out_write      = 1'b0;
    slot_free      = 1'b0;
    read_fifo      = 1'b0;
    key_change_ack = 1'b0;

    fin            = last_valid & bus.data_done;
    stall          = fin & bus.out_full;
    out_write      = fin & ~bus.out_full;
    slot_free      = ~last_valid | out_write;
    read_fifo      = slot_free & ~bus.fifo_empty & (state_q == RUN) &
                     ~bus.key_change_req;
    key_change_ack = (state_q == ACK);
  end

  assign bus.read_fifo      = read_fifo;
  assign bus.out_write      = out_write;
  assign bus.is_full        = stall;
  assign bus.key_change_ack = key_change_ack;
  assign bus.busy           = (inflight != '0);
  assign bus.inflight       = inflight;

endmodule

// File: tb/tb_aes_decrypt_scheduler.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_scheduler
// Reference model: each live block carries its age in non-stalled cycles
// since injection. A block sits at the ring output whenever its age is a
// multiple of the ring depth and is finished at age depth*done_state.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_scheduler;
  import aes_pkg::*;

  localparam int D   = AES_RING_DEPTH;
  localparam int LAT = AES_RING_DEPTH * int'(AES_DONE_STATE);

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;
  localparam int S_ACK   = 3;

  localparam int EV_RD   = 0;
  localparam int EV_OW   = 1;
  localparam int EV_FULL = 2;
  localparam int EV_ACK  = 3;

  logic clk = 1'b0;
  logic rst;

  aes_decrypt_scheduler_if bus ();

  aes_decrypt_scheduler #(
    .RING_DEPTH (AES_RING_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int ages[$];
  int m_state;
  bit model_valid;
  int pushed, popped, cyc;
  int n_checks, n_fail;
  int rd_n, ow_n, full_n, ack_n;
  int rd_at[0:4095];
  int ow_at[0:4095];
  int ack_at[0:4095];
  int max_inflight;
  bit bubble_force, bubble_rand;

  function automatic bit m_last_live();
    foreach (ages[i]) if (ages[i] % D == 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_fin();
    foreach (ages[i]) if (ages[i] % D == 0 && ages[i] == LAT) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int get_cnt(int which);
    case (which)
      EV_RD:   return rd_n;
      EV_OW:   return ow_n;
      EV_FULL: return full_n;
      default: return ack_n;
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int n);
    pushed += n;
    bus.fifo_empty = (pushed == popped);
  endtask

  // One clock: compare and advance the model at the falling edge, then
  // refresh the model-derived inputs just after the rising edge.
  task automatic tick();
    bit live, fin, stall, e_ow, e_rd, free;
    int nxt, idx;
    live = 0; fin = 0; stall = 0; e_ow = 0; e_rd = 0; free = 0;
    @(negedge clk);
    if (model_valid) begin
      live  = m_last_live();
      fin   = m_fin();
      stall = fin & bus.out_full;
      e_ow  = fin & !bus.out_full;
      free  = !live | e_ow;
      e_rd  = free && (pushed != popped) && (m_state == S_RUN) && !bus.key_change_req;
      check("read_fifo", int'(bus.read_fifo), int'(e_rd));
      check("out_write", int'(bus.out_write), int'(e_ow));
      check("is_full", int'(bus.is_full), int'(stall));
      check("key_change_ack", int'(bus.key_change_ack), int'(m_state == S_ACK));
      check("busy", int'(bus.busy), int'(ages.size() != 0));
      check("inflight", int'(bus.inflight), ages.size());
      if (bus.read_fifo && rd_n < 4096) rd_at[rd_n] = cyc;
      if (bus.read_fifo) rd_n++;
      if (bus.out_write && ow_n < 4096) ow_at[ow_n] = cyc;
      if (bus.out_write) ow_n++;
      if (bus.is_full) full_n++;
      if (bus.key_change_ack && ack_n < 4096) ack_at[ack_n] = cyc;
      if (bus.key_change_ack) ack_n++;
      if (int'(bus.inflight) > max_inflight) max_inflight = int'(bus.inflight);
    end
    if (e_rd) popped++;
    if (rst) begin
      ages.delete();
      m_state     = S_IDLE;
      model_valid = 1'b1;
    end else if (model_valid) begin
      nxt = ages.size() + int'(e_rd) - int'(e_ow);
      case (m_state)
        S_IDLE:  if (!stall && bus.key_valid && !bus.key_change_req) m_state = S_RUN;
        S_RUN: begin
          if (bus.key_change_req) m_state = S_DRAIN;
          else if (!stall && !bus.key_valid && ages.size() == 0) m_state = S_IDLE;
        end
        S_DRAIN: if (!stall && nxt == 0) m_state = S_ACK;
        default: m_state = S_IDLE;
      endcase
      if (!stall) begin
        if (e_ow) begin
          idx = -1;
          foreach (ages[i]) if (ages[i] == LAT) idx = i;
          if (idx >= 0) ages.delete(idx);
        end
        foreach (ages[i]) ages[i]++;
        if (e_rd) ages.push_back(1);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    bus.fifo_empty = (pushed == popped);
    bus.data_done  = m_fin() | (!m_last_live() &
                     (bubble_force | (bubble_rand & ($urandom_range(1, 0) == 1))));
  endtask

  task automatic wait_until(int which, int target, int budget, string name);
    int k;
    k = 0;
    while (get_cnt(which) < target && k < budget) begin
      tick();
      k++;
    end
    check(name, int'(get_cnt(which) >= target), 1);
  endtask

  int b_rd, b_ow, b_full, b_ack, rel_cyc;

  initial begin
    rst                = 1'b1;
    bus.fifo_empty     = 1'b1;
    bus.data_done      = 1'b0;
    bus.out_full       = 1'b0;
    bus.key_valid      = 1'b0;
    bus.key_change_req = 1'b0;
    bubble_force = 0; bubble_rand = 0;
    model_valid = 0; m_state = S_IDLE;
    pushed = 0; popped = 0; cyc = 0; n_checks = 0; n_fail = 0;
    rd_n = 0; ow_n = 0; full_n = 0; ack_n = 0; max_inflight = 0;

    repeat (3) tick();

    // single block: read one cycle after leaving IDLE, written LAT later
    rst = 1'b0;
    bus.key_valid = 1'b1;
    rel_cyc = cyc;
    b_rd = rd_n; b_ow = ow_n;
    push(1);
    wait_until(EV_RD, b_rd + 1, 10, "t1_read_seen");
    wait_until(EV_OW, b_ow + 1, 40, "t1_write_seen");
    check("t1_read_cycle", rd_at[b_rd] - rel_cyc, 1);
    check("t1_latency", ow_at[b_ow] - rd_at[b_rd], 30);
    repeat (3) tick();

    // five blocks back to back
    max_inflight = 0;
    b_rd = rd_n; b_ow = ow_n;
    push(5);
    wait_until(EV_OW, b_ow + 5, 120, "t2_writes_seen");
    check("t2_first_three_span", rd_at[b_rd + 2] - rd_at[b_rd], 2);
    check("t2_block4_inject", rd_at[b_rd + 3] - rd_at[b_rd], 30);
    check("t2_block5_inject", rd_at[b_rd + 4] - rd_at[b_rd], 31);
    check("t2_last_write", ow_at[b_ow + 4] - rd_at[b_rd], 61);
    check("t2_max_inflight", max_inflight, 3);
    repeat (3) tick();

    // output stall for 4 cycles
    b_rd = rd_n; b_ow = ow_n; b_full = full_n;
    bus.out_full = 1'b1;
    push(1);
    wait_until(EV_RD, b_rd + 1, 10, "t3_read_seen");
    wait_until(EV_FULL, b_full + 4, 50, "t3_stall_seen");
    bus.out_full = 1'b0;
    wait_until(EV_OW, b_ow + 1, 5, "t3_write_seen");
    repeat (2) tick();
    check("t3_stall_cycles", full_n - b_full, 4);
    check("t3_latency", ow_at[b_ow] - rd_at[b_rd], 34);
    check("t3_write_count", ow_n - b_ow, 1);

    // garbage data_done on bubbles
    b_ow = ow_n; b_full = full_n;
    bubble_force = 1'b1;
    repeat (12) tick();
    bubble_force = 1'b0;
    check("t4_bubble_writes", ow_n - b_ow, 0);
    check("t4_bubble_stalls", full_n - b_full, 0);

    // key change with two blocks in flight
    b_rd = rd_n; b_ow = ow_n; b_ack = ack_n;
    push(2);
    wait_until(EV_RD, b_rd + 2, 10, "t5_reads_seen");
    bus.key_change_req = 1'b1;
    push(1);
    wait_until(EV_ACK, b_ack + 1, 60, "t5_ack_seen");
    repeat (3) tick();
    check("t5_reads_after_req", rd_n - b_rd, 2);
    check("t5_writes", ow_n - b_ow, 2);
    check("t5_ack_after_retire", ack_at[b_ack] - ow_at[ow_n - 1], 1);
    check("t5_ack_pulses", ack_n - b_ack, 1);
    bus.key_change_req = 1'b0;
    b_ow = ow_n;
    wait_until(EV_OW, b_ow + 1, 50, "t5_pending_block_written");

    // reset with a full ring and a blocked output
    b_rd = rd_n;
    push(3);
    wait_until(EV_RD, b_rd + 3, 10, "t6_reads_seen");
    bus.out_full = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_read_fifo", int'(bus.read_fifo), 0);
    check("t6_out_write", int'(bus.out_write), 0);
    check("t6_is_full", int'(bus.is_full), 0);
    check("t6_ack", int'(bus.key_change_ack), 0);
    check("t6_busy", int'(bus.busy), 0);
    check("t6_inflight", int'(bus.inflight), 0);
    tick();
    bus.out_full = 1'b0;

    // randomized traffic
    bubble_rand = 1'b1;
    b_ack = ack_n;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3, 0) == 0 && (pushed - popped) < 8) push(1);
      bus.out_full = ($urandom_range(3, 0) == 0);
      if ($urandom_range(199, 0) == 0) bus.key_valid = ~bus.key_valid;
      if (!bus.key_change_req) begin
        if ($urandom_range(149, 0) == 0) begin
          bus.key_change_req = 1'b1;
          b_ack = ack_n;
        end
      end else if (ack_n != b_ack || $urandom_range(59, 0) == 0) begin
        bus.key_change_req = 1'b0;
      end
      rst = ($urandom_range(999, 0) == 0);
      tick();
    end
    rst = 1'b0;
    bus.out_full = 1'b0;
    bus.key_change_req = 1'b0;
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
